// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank: C_NUM_REGS read/write control words and
// C_NUM_STATUS read-only status words behind one OPB address window.
// Control words support byte enables and an optional self-clearing mode.
// OPB buses are big-endian ([0:31]). User-side buses are little-endian.

// One control word: byte-masked write; pulse words fall back after one cycle.
module opb_ctrl_word #(
    parameter logic [31:0] RST_VAL = 32'h0,
    parameter bit          PULSE   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] q
);
    // Byte-lane update on write; pulse words return to the reset value next edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) q[8*b +: 8] <= wdata[8*b +: 8];
        end else if (PULSE) begin
            q <= RST_VAL;
        end
    end
endmodule

module opb_register_bank_ppc2simulink #(
    parameter logic [31:0]           C_BASEADDR    = 32'h01000B00,
    parameter logic [31:0]           C_HIGHADDR    = 32'h01000BFF,
    parameter int                    C_OPB_AWIDTH  = 32,
    parameter int                    C_OPB_DWIDTH  = 32,
    parameter int                    C_NUM_REGS    = 4,
    parameter int                    C_NUM_STATUS  = 2,
    parameter logic [31:0]           C_REG_RST_VAL = 32'h0,
    parameter logic [C_NUM_REGS-1:0] C_PULSE_MASK  = '0,
    parameter                        C_FAMILY      = "virtex5"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:31]               OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:31]               OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:31]               Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic [32*C_NUM_REGS-1:0]  user_data_out,
    output logic [C_NUM_REGS-1:0]     user_wr_strobe,
    input  logic [32*C_NUM_STATUS-1:0] user_data_in
);
    // Only a 32-bit OPB is supported; any other width never decodes a hit.
    localparam bit CFG_OK = (C_OPB_DWIDTH == 32) && (C_OPB_AWIDTH == 32);

    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

    state_t                state, state_nxt;
    logic [31:0]           addr, wdata, offs, rd_mux, rd_q;
    logic [3:0]            be;
    logic [29:0]           idx;
    logic                  hit, take;
    logic [C_NUM_REGS-1:0] wr_sel, strobe_q;
    logic                  unused_bits;

    // Packed [0:31] -> [31:0] copies OPB bit k to user bit 31-k.
    assign addr  = OPB_ABus;
    assign wdata = OPB_DBus;
    assign be    = OPB_BE;
    assign offs  = addr - C_BASEADDR;
    assign idx   = offs[31:2];
    // Burst hint and byte offset inside a word are deliberately ignored.
    assign unused_bits = ^{OPB_seqAddr, offs[1:0]};

    assign hit  = CFG_OK && OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign take = (state == IDLE) && hit;

    // Per-word write select: only in-range control words get written/strobed
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < C_NUM_REGS; i++)
            wr_sel[i] = take && !OPB_RNW && (idx == 30'(i));
    end

    // Read mux: control words, then status words, anything else reads zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < C_NUM_REGS; i++)
            if (idx == 30'(i)) rd_mux = user_data_out[32*i +: 32];
        for (int j = 0; j < C_NUM_STATUS; j++)
            if (idx == 30'(C_NUM_REGS + j)) rd_mux = user_data_in[32*j +: 32];
    end

    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_word
        opb_ctrl_word #(
            .RST_VAL (C_REG_RST_VAL),
            .PULSE   (C_PULSE_MASK[i])
        ) u_word (
            .clk   (OPB_Clk),
            .rst_n (OPB_Rst_n),
            .wr_en (wr_sel[i]),
            .be    (be),
            .wdata (wdata),
            .q     (user_data_out[32*i +: 32])
        );
    end

    // FSM state register
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next state: HOLD swallows the cycle in which the master drops select
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hit) state_nxt = ACK;
            ACK:     state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read data and write strobes are live only during the ACK cycle
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            rd_q     <= '0;
            strobe_q <= '0;
        end else begin
            rd_q     <= (take && OPB_RNW) ? rd_mux : 32'h0;
            strobe_q <= wr_sel;
        end
    end

    assign Sl_xferAck     = (state == ACK);
    assign Sl_DBus        = rd_q;
    assign user_wr_strobe = strobe_q;
    assign Sl_errAck      = 1'b0;
    assign Sl_retry       = 1'b0;
    assign Sl_toutSup     = 1'b0;
endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Randomized scoreboard bench for opb_register_bank_ppc2simulink.
module tb_opb_register_bank_ppc2simulink;
    localparam logic [31:0] BASE  = 32'h01000B00;
    localparam logic [31:0] HIGH  = 32'h01000BFF;
    localparam logic [3:0]  PMASK = 4'b0001;

    logic          OPB_Clk = 1'b0;
    logic          OPB_Rst_n = 1'b0;
    logic [0:31]   OPB_ABus = '0, OPB_DBus = '0, Sl_DBus;
    logic [0:3]    OPB_BE = '0;
    logic          OPB_RNW = 1'b0, OPB_select = 1'b0, OPB_seqAddr = 1'b0;
    logic          Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
    logic [127:0]  user_data_out;
    logic [3:0]    user_wr_strobe;
    logic [63:0]   user_data_in = '0;

    always #5 OPB_Clk = ~OPB_Clk;

    opb_register_bank_ppc2simulink #(.C_PULSE_MASK(PMASK)) dut (
        .OPB_Clk(OPB_Clk), .OPB_Rst_n(OPB_Rst_n), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
        .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
        .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
        .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
        .user_data_out(user_data_out), .user_wr_strobe(user_wr_strobe),
        .user_data_in(user_data_in)
    );

    typedef struct {
        logic [31:0]  rd;
        logic [3:0]   stb;
        logic [127:0] ud_at;
        logic [127:0] ud_after;
    } exp_t;

    exp_t         sbq[$];
    int           n_vec = 0, n_bad = 0;
    logic [31:0]  ctrl [4];
    bit           chk_next = 1'b0;
    logic [127:0] after_exp;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_ctrl();
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = ctrl[i];
        return r;
    endfunction

    // Reference model: word-indexed register file, byte masks, pulse words.
    function automatic exp_t model(input logic [31:0] addr, input bit rnw,
                                   input logic [0:3] be, input logic [31:0] data);
        exp_t e;
        logic [31:0] mask;
        int wi;
        wi = int'((addr - BASE) >> 2);
        mask = '0;
        for (int k = 0; k < 4; k++) if (be[k]) mask[31-8*k -: 8] = 8'hFF;
        e.rd = '0;
        e.stb = '0;
        if (rnw) begin
            if (wi < 4)      e.rd = ctrl[wi];
            else if (wi < 6) e.rd = user_data_in[32*(wi-4) +: 32];
        end else if (wi < 4) begin
            ctrl[wi] = (ctrl[wi] & ~mask) | (data & mask);
            e.stb = 4'(1 << wi);
        end
        e.ud_at = pack_ctrl();
        for (int i = 0; i < 4; i++) if (PMASK[i]) ctrl[i] = '0;
        e.ud_after = pack_ctrl();
        return e;
    endfunction

    task automatic xfer(input logic [31:0] addr, input bit rnw,
                        input logic [0:3] be, input logic [31:0] data);
        bit hit, got;
        hit = (addr >= BASE) && (addr <= HIGH);
        if (hit) sbq.push_back(model(addr, rnw, be, data));
        @(posedge OPB_Clk); #1;
        OPB_ABus = addr; OPB_DBus = data; OPB_BE = be; OPB_RNW = rnw; OPB_select = 1'b1;
        got = 1'b0;
        for (int c = 0; c < (hit ? 8 : 5); c++) begin
            @(posedge OPB_Clk); #1;
            if (Sl_xferAck) begin got = 1'b1; break; end
        end
        OPB_select = 1'b0;
        if (hit) chk("ack_seen", 128'(got), 128'(1));
        else     chk("nohit_ack", 128'(got), 128'(0));
    endtask

    // Monitor: pops one expectation per ack, checks quiet outputs otherwise
    always @(negedge OPB_Clk) begin : mon
        exp_t e;
        if (OPB_Rst_n) begin
            if (Sl_xferAck) begin
                if (sbq.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL spurious_ack: got ack with empty scoreboard");
                end else begin
                    e = sbq.pop_front();
                    chk("rd_data", 128'(Sl_DBus), 128'(e.rd));
                    chk("wr_strobe", 128'(user_wr_strobe), 128'(e.stb));
                    chk("ud_at_ack", user_data_out, e.ud_at);
                    after_exp = e.ud_after;
                    chk_next = 1'b1;
                end
            end else begin
                chk("idle_dbus", 128'(Sl_DBus), 128'(0));
                chk("idle_strobe", 128'(user_wr_strobe), 128'(0));
                if (chk_next) begin
                    chk("ud_after_ack", user_data_out, after_exp);
                    chk_next = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [5:0] held;
        logic [31:0] a;
        int wi;
        for (int i = 0; i < 4; i++) ctrl[i] = '0;
        user_data_in = {$urandom, $urandom};
        repeat (3) @(posedge OPB_Clk);
        #1;
        chk("rst_ack", 128'(Sl_xferAck), 128'(0));
        chk("rst_dbus", 128'(Sl_DBus), 128'(0));
        chk("rst_ud", user_data_out, 128'(0));
        chk("rst_strobe", 128'(user_wr_strobe), 128'(0));
        chk("tieoffs", 128'({Sl_errAck, Sl_retry, Sl_toutSup}), 128'(0));
        OPB_Rst_n = 1'b1;

        // Directed items
        xfer(BASE, 1'b1, 4'b1111, 32'h0);
        xfer(BASE + 4, 1'b0, 4'b1111, 32'hDEADBEEF);
        xfer(BASE + 4, 1'b1, 4'b1111, 32'h0);
        xfer(BASE + 4, 1'b0, 4'b0101, 32'h11223344);
        xfer(BASE + 4, 1'b1, 4'b0000, 32'h0);
        chk("be_merge_model", 128'(ctrl[1]), 128'(32'hDE22BE44));
        xfer(BASE, 1'b0, 4'b1111, 32'h00000001);
        xfer(BASE, 1'b1, 4'b1111, 32'h0);
        user_data_in[31:0] = 32'hCAFEF00D;
        xfer(BASE + 32'h10, 1'b1, 4'b1111, 32'h0);
        xfer(BASE + 32'h10, 1'b0, 4'b1111, 32'h55555555);
        xfer(BASE + 32'hF0, 1'b1, 4'b1111, 32'h0);
        xfer(BASE + 32'h9, 1'b0, 4'b0000, 32'hFFFFFFFF);
        xfer(BASE - 4, 1'b1, 4'b1111, 32'h0);
        xfer(HIGH + 1, 1'b0, 4'b1111, 32'h12345678);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) user_data_in = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) begin
                a = ($urandom_range(0, 1) == 1) ? BASE - 32'(4 * $urandom_range(1, 64))
                                                : HIGH + 32'(1 + $urandom_range(0, 255));
            end else begin
                wi = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 6);
                a = BASE + 32'(4 * wi) + 32'($urandom_range(0, 3));
            end
            xfer(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge OPB_Clk);
        end

        // Select held for six cycles: acks only on the 1st and 4th cycles
        repeat (3) @(posedge OPB_Clk);
        sbq.push_back(model(BASE + 4, 1'b1, 4'b1111, 32'h0));
        sbq.push_back(model(BASE + 4, 1'b1, 4'b1111, 32'h0));
        #1;
        OPB_ABus = BASE + 4; OPB_RNW = 1'b1; OPB_BE = 4'b1111; OPB_select = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge OPB_Clk); #1;
            held[5-c] = Sl_xferAck;
        end
        OPB_select = 1'b0;
        chk("held_select_acks", 128'(held), 128'(6'b100100));
        repeat (3) @(posedge OPB_Clk);

        // Reset asserted during ACK of a write
        #1;
        OPB_ABus = BASE + 8; OPB_RNW = 1'b0; OPB_BE = 4'b1111;
        OPB_DBus = 32'h12345678; OPB_select = 1'b1;
        @(posedge OPB_Clk); #1;
        chk("pre_rst_ack", 128'(Sl_xferAck), 128'(1));
        chk("pre_rst_word2", 128'(user_data_out[95:64]), 128'(32'h12345678));
        OPB_Rst_n = 1'b0;
        #1;
        OPB_select = 1'b0;
        chk("mid_rst_ack", 128'(Sl_xferAck), 128'(0));
        chk("mid_rst_ud", user_data_out, 128'(0));
        chk("mid_rst_strobe", 128'(user_wr_strobe), 128'(0));
        for (int i = 0; i < 4; i++) ctrl[i] = '0;
        @(posedge OPB_Clk); #1;
        OPB_Rst_n = 1'b1;
        xfer(BASE + 8, 1'b1, 4'b1111, 32'h0);

        repeat (3) @(posedge OPB_Clk);
        chk("sb_drain", 128'(sbq.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
